// File: rtl/queue_uart_tx.sv
// queue_uart_tx: reader end of a registered byte queue. Pops one byte per frame
// over the available/data/ack handshake and serialises it LSB-first as an 8N1 or
// 8N2 UART frame on tx. Latency: the start bit begins on the edge that takes the byte.
// Backpressure: while a frame is in progress the queue is ignored and no ack is issued.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   enable       1 = start new frames; 0 = finish the current frame, then hold
//   q_available  queue non-empty (registered by the queue)
//   q_data       byte at the queue read pointer (registered by the queue)
//   q_ack        one-cycle pop pulse to the queue
//   tx           serial line, idles high
//   busy         high while a frame is in progress
//   tx_count     completed frames, modulo 2^16

module queue_uart_tx #(
  parameter int CLKS_PER_BIT = 104,  // >= 2
  parameter int STOP_BITS    = 1     // 1 or 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        q_available,
  input  logic [7:0]  q_data,
  output logic        q_ack,
  output logic        tx,
  output logic        busy,
  output logic [15:0] tx_count
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  // Stop-bit counter is one bit wide; its terminal value depends on STOP_BITS.
  localparam logic STOP_LAST = (STOP_BITS == 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic          stop_cnt;
  logic [7:0]    shreg;

  logic       baud_done;
  logic [2:0] next_bit;

  assign baud_done = (baud == BAUD_LAST);
  assign next_bit  = bit_idx + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= 3'd0;
      stop_cnt <= 1'b0;
      shreg    <= 8'h00;
      tx       <= 1'b1;
      q_ack    <= 1'b0;
      busy     <= 1'b0;
      tx_count <= 16'h0000;
    end else begin
      // The ack is a single-cycle pulse: whatever set it last edge, it clears now.
      q_ack <= 1'b0;

      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          baud     <= '0;
          bit_idx  <= 3'd0;
          stop_cnt <= 1'b0;
          // The byte is captured on the acking edge, so the queue moving on
          // afterwards cannot disturb the frame. The queue's registered view
          // lags the pop by one more cycle; a bit period of at least two clocks
          // keeps us from looking at it again before it has caught up.
          if (enable && q_available) begin
            shreg <= q_data;
            tx    <= 1'b0;
            q_ack <= 1'b1;
            busy  <= 1'b1;
            state <= S_START;
          end
        end

        S_START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= 3'd0;
            tx      <= shreg[0];
            state   <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= S_STOP;
            end else begin
              bit_idx <= next_bit;
              tx      <= shreg[next_bit];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

        S_STOP: begin
          tx <= 1'b1;
          if (baud_done) begin
            baud <= '0;
            if (stop_cnt == STOP_LAST) begin
              // Leaving for IDLE guarantees one idle clock before the next start.
              tx_count <= tx_count + 16'd1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
